// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared memory.
// The master modport is the arbiter's view; slave is the view of the surrounding system.
interface mem_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic [WIDTH-1:0] if_rdata;
  logic             if_ready;

  logic             dm_req;
  logic             dm_we;
  logic [WIDTH-1:0] dm_addr;
  logic [WIDTH-1:0] dm_wdata;
  logic [2:0]       dm_mode;
  logic [WIDTH-1:0] dm_rdata;
  logic             dm_ready;

  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [2:0]       mem_mode;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  logic             stall;
  logic             err;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_mode,
           mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready,
           mem_req, mem_we, mem_addr, mem_wdata, mem_mode, stall, err
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_mode,
           mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
           mem_req, mem_we, mem_addr, mem_wdata, mem_mode, stall, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one single-port memory,
// with round-robin tie-breaking, a wait-cycle timeout and a sticky error flag.
module mem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input logic            clk,
  input logic            rst,
  mem_arbiter_if.master  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DATA  = 2'd1;
  localparam logic [1:0] FETCH = 2'd2;

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]       state_reg;
  logic [CW-1:0]    wait_cnt_reg;
  logic             last_grant_dm_reg;
  logic             mem_req_reg;
  logic             mem_we_reg;
  logic [WIDTH-1:0] mem_addr_reg;
  logic [WIDTH-1:0] mem_wdata_reg;
  logic [2:0]       mem_mode_reg;
  logic [WIDTH-1:0] if_rdata_reg;
  logic             if_ready_reg;
  logic [WIDTH-1:0] dm_rdata_reg;
  logic             dm_ready_reg;
  logic             err_reg;

  logic if_pend;
  logic dm_pend;
  logic grant_dm;
  logic grant_if;
  logic timeout_hit;

  // A requester whose ready pulse is showing is still holding req; skip it.
  always_comb begin
    if_pend     = bus.if_req & ~if_ready_reg;
    dm_pend     = bus.dm_req & ~dm_ready_reg;
    grant_dm    = dm_pend & (~if_pend | ~last_grant_dm_reg);
    grant_if    = if_pend & ~grant_dm;
    timeout_hit = (wait_cnt_reg == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      wait_cnt_reg      <= '0;
      last_grant_dm_reg <= 1'b0;
      mem_req_reg       <= 1'b0;
      mem_we_reg        <= 1'b0;
      mem_addr_reg      <= '0;
      mem_wdata_reg     <= '0;
      mem_mode_reg      <= 3'b000;
      if_rdata_reg      <= '0;
      if_ready_reg      <= 1'b0;
      dm_rdata_reg      <= '0;
      dm_ready_reg      <= 1'b0;
      err_reg           <= 1'b0;
    end else begin
      if_ready_reg <= 1'b0;
      dm_ready_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_dm) begin
            state_reg         <= DATA;
            mem_req_reg       <= 1'b1;
            mem_we_reg        <= bus.dm_we;
            mem_addr_reg      <= bus.dm_addr;
            mem_wdata_reg     <= bus.dm_wdata;
            mem_mode_reg      <= bus.dm_mode;
            last_grant_dm_reg <= 1'b1;
            wait_cnt_reg      <= '0;
          end else if (grant_if) begin
            state_reg         <= FETCH;
            mem_req_reg       <= 1'b1;
            mem_we_reg        <= 1'b0;
            mem_addr_reg      <= bus.if_addr;
            mem_wdata_reg     <= '0;
            mem_mode_reg      <= 3'b010;
            last_grant_dm_reg <= 1'b0;
            wait_cnt_reg      <= '0;
          end
        end
        DATA, FETCH: begin
          // Ack wins over a coinciding timeout; a timeout completes with zero data.
          if (bus.mem_ack || timeout_hit) begin
            state_reg   <= IDLE;
            mem_req_reg <= 1'b0;
            if (state_reg == DATA) begin
              dm_ready_reg <= 1'b1;
              dm_rdata_reg <= (bus.mem_ack && !mem_we_reg) ? bus.mem_rdata : '0;
            end else begin
              if_ready_reg <= 1'b1;
              if_rdata_reg <= bus.mem_ack ? bus.mem_rdata : '0;
            end
            if (!bus.mem_ack) begin
              err_reg <= 1'b1;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          mem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.mem_mode  = mem_mode_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.if_ready  = if_ready_reg;
  assign bus.dm_rdata  = dm_rdata_reg;
  assign bus.dm_ready  = dm_ready_reg;
  assign bus.err       = err_reg;
  assign bus.stall     = (bus.if_req & ~if_ready_reg) | (bus.dm_req & ~dm_ready_reg);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays the memory and both requesters,
// checking outputs 1 ns after each rising edge against hand-computed values.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mem_arbiter_if #(.WIDTH(32)) bus ();

  mem_arbiter #(.WIDTH(32), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst           = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.dm_mode   = 3'b000;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_mem_req",   32'(bus.mem_req), 32'd0);
    check("rst_mem_we",    32'(bus.mem_we), 32'd0);
    check("rst_mem_addr",  bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mem_mode",  32'(bus.mem_mode), 32'd0);
    check("rst_ready",     32'({bus.if_ready, bus.dm_ready}), 32'd0);
    check("rst_rdata",     bus.if_rdata | bus.dm_rdata, 32'd0);
    check("rst_err",       32'(bus.err), 32'd0);
    check("rst_stall",     32'(bus.stall), 32'd0);
    $display("vec reset: checked reset values");

    // Fetch only
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0010;
    #1;
    check("f1_stall_req", 32'(bus.stall), 32'd1);
    tick();
    check("f1_mem_req",  32'(bus.mem_req), 32'd1);
    check("f1_mem_we",   32'(bus.mem_we), 32'd0);
    check("f1_mem_addr", bus.mem_addr, 32'h10);
    check("f1_mem_mode", 32'(bus.mem_mode), 32'd2);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0050_0093;
    tick();
    bus.mem_ack = 1'b0;
    check("f1_if_ready", 32'(bus.if_ready), 32'd1);
    check("f1_if_rdata", bus.if_rdata, 32'h0050_0093);
    check("f1_mem_req0", 32'(bus.mem_req), 32'd0);
    check("f1_stall0",   32'(bus.stall), 32'd0);
    tick();
    bus.if_req = 1'b0;
    check("f1_pulse1",  32'(bus.if_ready), 32'd0);
    check("f1_nodup_a", 32'(bus.mem_req), 32'd0);
    tick();
    check("f1_nodup_b", 32'(bus.mem_req), 32'd0);
    $display("vec fetch_only: addr 0x10 rdata 0x00500093");

    // Simultaneous requests from reset: data first, then fetch
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0000_0020;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h0000_0100;
    bus.dm_wdata = 32'hDEAD_BEEF;
    bus.dm_mode  = 3'b101;
    tick();
    check("s1_mem_req",   32'(bus.mem_req), 32'd1);
    check("s1_mem_we",    32'(bus.mem_we), 32'd1);
    check("s1_mem_addr",  bus.mem_addr, 32'h100);
    check("s1_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("s1_mem_mode",  32'(bus.mem_mode), 32'd5);
    check("s1_stall",     32'(bus.stall), 32'd1);
    tick();
    check("s1_hold_req",  32'(bus.mem_req), 32'd1);
    check("s1_hold_addr", bus.mem_addr, 32'h100);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    tick();
    bus.mem_ack = 1'b0;
    check("s1_dm_ready", 32'(bus.dm_ready), 32'd1);
    check("s1_dm_rdata", bus.dm_rdata, 32'd0);
    check("s1_if_ready", 32'(bus.if_ready), 32'd0);
    check("s1_stall_if", 32'(bus.stall), 32'd1);
    bus.dm_req = 1'b0;
    tick();
    check("s2_mem_req",  32'(bus.mem_req), 32'd1);
    check("s2_mem_we",   32'(bus.mem_we), 32'd0);
    check("s2_mem_addr", bus.mem_addr, 32'h20);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_0001;
    tick();
    bus.mem_ack = 1'b0;
    check("s2_if_ready", 32'(bus.if_ready), 32'd1);
    check("s2_if_rdata", bus.if_rdata, 32'hCAFE_0001);
    check("s2_stall0",   32'(bus.stall), 32'd0);
    bus.if_req = 1'b0;
    $display("vec simultaneous: data 0x100 then fetch 0x20");

    // Data-only load, then a simultaneous pair after a data grant: fetch wins
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h0000_0200;
    tick();
    check("l1_mem_addr", bus.mem_addr, 32'h200);
    check("l1_mem_we",   32'(bus.mem_we), 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hA5A5_A5A5;
    tick();
    bus.mem_ack = 1'b0;
    check("l1_dm_ready", 32'(bus.dm_ready), 32'd1);
    check("l1_dm_rdata", bus.dm_rdata, 32'hA5A5_A5A5);
    bus.dm_req = 1'b0;
    tick();
    check("l1_idle", 32'(bus.mem_req), 32'd0);
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0000_0030;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h0000_0300;
    bus.dm_wdata = 32'h0000_0011;
    tick();
    check("r2_fetch_first", bus.mem_addr, 32'h30);
    check("r2_fetch_we",    32'(bus.mem_we), 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BAD_0030;
    tick();
    bus.mem_ack = 1'b0;
    check("r2_if_ready", 32'(bus.if_ready), 32'd1);
    check("r2_if_rdata", bus.if_rdata, 32'h0BAD_0030);
    bus.if_req = 1'b0;
    tick();
    check("r2_data_addr",  bus.mem_addr, 32'h300);
    check("r2_data_wdata", bus.mem_wdata, 32'h11);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("r2_dm_ready", 32'(bus.dm_ready), 32'd1);
    check("r2_dm_rdata", bus.dm_rdata, 32'd0);
    bus.dm_req = 1'b0;
    $display("vec round_robin: fetch 0x30 before data 0x300");

    // Stray ack while idle
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    check("sa_ready_a", 32'({bus.if_ready, bus.dm_ready}), 32'd0);
    check("sa_req_a",   32'(bus.mem_req), 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    check("sa_ready_b", 32'({bus.if_ready, bus.dm_ready}), 32'd0);
    check("sa_rdata",   bus.dm_rdata, 32'd0);
    $display("vec stray_ack: ignored while idle");

    // Timeout: 16 cycles of mem_req with no ack
    bus.mem_rdata = 32'h0000_BBBB;
    bus.dm_req    = 1'b1;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = 32'h0000_0400;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("to_req_c%0d", i), 32'(bus.mem_req), 32'd1);
      check($sformatf("to_err_c%0d", i), 32'(bus.err), 32'd0);
    end
    tick();
    check("to_mem_req0", 32'(bus.mem_req), 32'd0);
    check("to_dm_ready", 32'(bus.dm_ready), 32'd1);
    check("to_dm_rdata", bus.dm_rdata, 32'd0);
    check("to_err",      32'(bus.err), 32'd1);
    bus.dm_req = 1'b0;
    tick();
    tick();
    check("to_err_sticky", 32'(bus.err), 32'd1);
    check("to_pulse1",     32'(bus.dm_ready), 32'd0);
    $display("vec timeout: err set after 16 wait cycles");

    // Reset two cycles into a fetch, then a late ack
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0040;
    tick();
    check("rw_mem_req", 32'(bus.mem_req), 32'd1);
    tick();
    rst        = 1'b1;
    bus.if_req = 1'b0;
    tick();
    rst         = 1'b0;
    bus.mem_ack = 1'b1;
    check("rw_mem_req0",  32'(bus.mem_req), 32'd0);
    check("rw_mem_addr",  bus.mem_addr, 32'd0);
    check("rw_mem_mode",  32'(bus.mem_mode), 32'd0);
    check("rw_if_rdata",  bus.if_rdata, 32'd0);
    check("rw_err",       32'(bus.err), 32'd0);
    tick();
    check("rw_no_ready_a", 32'(bus.if_ready), 32'd0);
    check("rw_req_a",      32'(bus.mem_req), 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    check("rw_no_ready_b", 32'(bus.if_ready), 32'd0);
    check("rw_rdata_b",    bus.if_rdata, 32'd0);
    $display("vec reset_mid_wait: fetch abandoned");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, sets the width of address and data.
REQ-002 Parameter TIMEOUT, default 16, sets the maximum number of cycles to wait for mem_ack after mem_req is raised.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  fetch request; held high until if_ready.
REQ-006 if_addr  in  WIDTH  fetch byte address.
REQ-007 if_rdata  out  WIDTH  fetched instruction; valid while if_ready=1.
REQ-008 if_ready  out  1  one-cycle fetch-complete pulse.
REQ-009 dm_req  in  1  data request; held high until dm_ready.
REQ-010 dm_we  in  1  1 = store, 0 = load.
REQ-011 dm_addr  in  WIDTH  data byte address.
REQ-012 dm_wdata  in  WIDTH  store data.
REQ-013 dm_mode  in  3  access size/sign code; passed through unchanged.
REQ-014 dm_rdata  out  WIDTH  load data; valid while dm_ready=1.
REQ-015 dm_ready  out  1  one-cycle data-complete pulse.
REQ-016 mem_req  out  1  request to the shared single-port memory.
REQ-017 mem_we, mem_addr, mem_wdata, mem_mode  out  1/WIDTH/WIDTH/3  latched transaction fields.
REQ-018 mem_rdata  in  WIDTH  memory read data; valid with mem_ack.
REQ-019 mem_ack  in  1  memory completion, sampled only while mem_req=1.
REQ-020 stall  out  1  combinational: (if_req & ~if_ready) | (dm_req & ~dm_ready).
REQ-021 err  out  1  sticky timeout flag.

Function
REQ-022 FSM states: IDLE, DATA, FETCH; all outputs except stall are registered.
REQ-023 IDLE, request pending: the arbiter grants the request. It latches addr/wdata/we/mode (fetch: we=0, mode=3'b010), sets mem_req=1 on the next edge and enters DATA or FETCH.
REQ-024 Both requests pending in IDLE: data wins unless the previous grant was data, in which case fetch wins. A last_grant flag holds the previous grant and resets to fetch.
REQ-025 IDLE ignores the requester whose ready is high in the same cycle, so a requester that is dropping its request is not granted a duplicate transaction.
REQ-026 DATA/FETCH: mem_req and all mem_* fields stay constant until mem_ack=1 or timeout.
REQ-027 mem_ack=1 in DATA: on the next edge, mem_req=0, dm_rdata=mem_rdata (0 for stores), dm_ready=1 for one cycle, state returns to IDLE. FETCH behaves the same with the if_* outputs.
REQ-028 Latency: request seen in IDLE at cycle N; mem_req=1 from N+1; ack at cycle A gives ready=1 at A+1. Minimum request-to-ready is 2 cycles (ack at N+1).
REQ-029 A wait counter clears on grant and increments each cycle in DATA/FETCH without ack.
REQ-030 Counter reaching TIMEOUT-1 without ack: on the next edge, mem_req=0, the ready pulse is issued with rdata=0, err=1, and state returns to IDLE.
REQ-031 err stays high until rst.
REQ-032 mem_ack and timeout in the same cycle: ack takes precedence, err unchanged.
REQ-033 Requester drops req mid-transaction: the transaction still completes and the ready pulse is still issued.
REQ-034 mem_ack while mem_req=0 is ignored.
REQ-035 Back-to-back: after ready, at least one IDLE cycle occurs before the next mem_req.

Reset
REQ-036 rst=1 at an edge: state=IDLE, mem_req=0, mem_we=0, mem_addr=mem_wdata=0, mem_mode=0, if_ready=dm_ready=0, if_rdata=dm_rdata=0, counter=0, last_grant=fetch, err=0.
REQ-037 Reset mid-transaction abandons it with no ready pulse; later mem_ack is ignored.

Verification
REQ-038 Fetch only: if_req=1, if_addr=0x0000_0010, mem_ack one cycle after mem_req with mem_rdata=0x0050_0093 -> mem_we=0, mem_addr=0x10, if_ready pulse 2 cycles after the request with if_rdata=0x0050_0093, stall=0 on the pulse cycle.
REQ-039 Simultaneous: if_req=dm_req=1 from reset, dm_we=1, dm_addr=0x100, dm_wdata=0xDEAD_BEEF -> data served first (mem_we=1, mem_wdata=0xDEADBEEF), then fetch; next simultaneous pair serves fetch first; stall=1 throughout until each port's ready.
REQ-040 Timeout: dm_req=1, mem_ack held 0 -> mem_req drops after 16 cycles, dm_ready pulse with dm_rdata=0, err=1 and stays 1 until rst.
REQ-041 Reset mid-wait: rst pulsed 2 cycles into FETCH, then mem_ack=1 -> no if_ready pulse, all outputs at reset values, err=0.
REQ-042 No duplicate: requester holds req through the ready cycle and drops it one cycle later -> exactly one mem_req transaction per request.
REQ-043 Stray ack: mem_ack=1 while IDLE -> no ready pulse, no state change.
